vga_text_console_writer: RTL and testbench

VGA_TEXT_CONSOLE_WRITER -- requirements
Module: vga_text_console_writer

---
 rtl/vga_text_console_pkg.sv | 41 ++++
 rtl/vga_text_console_writer_if.sv | 51 +++++
 rtl/vga_text_cell_addr.sv | 30 +++
 rtl/vga_text_console_writer.sv | 223 ++++++++++++++++++++++
 tb/tb_vga_text_console_writer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_text_console_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : vga_text_console_pkg                                          |
// | Purpose   : Shared geometry, control codes and FSM state type for the     |
// |             80x30 VGA text console writer.                                |
// | Ports     : none (package)                                                |
// | Config    : VGA_CONSOLE_LINE_CLEAR_EN adds the CLR_LINE state.            |
// | Revision  : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package vga_text_console_pkg;

  // Screen geometry
  localparam int COLS    = 80;
  localparam int ROWS    = 30;
  localparam int CELLS   = COLS * ROWS;   // 2400
  localparam int CELL_AW = 12;            // enough for 0..2399
  localparam int COL_W   = 7;             // 0..79
  localparam int ROW_W   = 5;             // 0..29

  // Control codes (everything else is printable)
  localparam logic [7:0] C_BS = 8'h08;    // backspace
  localparam logic [7:0] C_HT = 8'h09;    // horizontal tab
  localparam logic [7:0] C_LF = 8'h0A;    // line feed
  localparam logic [7:0] C_FF = 8'h0C;    // form feed: blank the screen
  localparam logic [7:0] C_CR = 8'h0D;    // carriage return

  // RST_HOLD is only occupied while rst is asserted; it keeps ready and busy
  // low during reset and forces the power-up blank on the first free cycle.
  typedef enum logic [1:0] {
    RST_HOLD   = 2'd0,
    IDLE       = 2'd1,
    CLR_SCREEN = 2'd2
`ifdef VGA_CONSOLE_LINE_CLEAR_EN
    ,
    CLR_LINE   = 2'd3
`endif
  } state_t;

endpackage

`default_nettype wire

// File: rtl/vga_text_console_writer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : vga_text_console_writer_if                                    |
// | Purpose   : Character handshake plus character/colour map write ports     |
// |             and cursor/busy status of the text console writer.            |
// | Signals   : char_valid_i/char_data_i/color_i  - character offer           |
// |             char_ready_o                      - writer accepts offer      |
// |             ch_map_*  / col_map_*             - map write ports           |
// |             cursor_x_o / cursor_y_o / busy_o  - status                    |
// | Modports  : master (character source), slave (console writer)             |
// | Revision  : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface vga_text_console_writer_if;
  import vga_text_console_pkg::*;

  logic               char_valid_i;
  logic [7:0]         char_data_i;
  logic [7:0]         color_i;
  logic               char_ready_o;

  logic               ch_map_wen_o;
  logic [CELL_AW-1:0] ch_map_addr_o;
  logic [7:0]         ch_map_data_o;

  logic               col_map_wen_o;
  logic [CELL_AW-1:0] col_map_addr_o;
  logic [7:0]         col_map_data_o;

  logic [COL_W-1:0]   cursor_x_o;
  logic [ROW_W-1:0]   cursor_y_o;
  logic               busy_o;

  modport master (
    output char_valid_i, char_data_i, color_i,
    input  char_ready_o,
    input  ch_map_wen_o, ch_map_addr_o, ch_map_data_o,
    input  col_map_wen_o, col_map_addr_o, col_map_data_o,
    input  cursor_x_o, cursor_y_o, busy_o
  );

  modport slave (
    input  char_valid_i, char_data_i, color_i,
    output char_ready_o,
    output ch_map_wen_o, ch_map_addr_o, ch_map_data_o,
    output col_map_wen_o, col_map_addr_o, col_map_data_o,
    output cursor_x_o, cursor_y_o, busy_o
  );

endinterface

`default_nettype wire

// File: rtl/vga_text_cell_addr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : vga_text_cell_addr                                            |
// | Purpose   : Linear cell address y*80+x for the 80x30 text map, built from |
// |             shifts and adds: (y<<6) + (y<<4) + x.                         |
// | Ports     : y    in  5  row 0..29                                         |
// |             x    in  7  column 0..79                                      |
// |             addr out 12 cell address 0..2399 (combinational)              |
// | Revision  : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module vga_text_cell_addr
  import vga_text_console_pkg::*;
(
  input  wire logic [ROW_W-1:0]   y,
  input  wire logic [COL_W-1:0]   x,
  output logic      [CELL_AW-1:0] addr
);

  logic [CELL_AW-1:0] w_y_ext;
  logic [CELL_AW-1:0] w_x_ext;

  assign w_y_ext = {{(CELL_AW-ROW_W){1'b0}}, y};
  assign w_x_ext = {{(CELL_AW-COL_W){1'b0}}, x};

  // 80 = 64 + 16; y<=29 keeps the sum inside 12 bits
  assign addr = (w_y_ext << 6) + (w_y_ext << 4) + w_x_ext;

endmodule

`default_nettype wire

// File: rtl/vga_text_console_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : vga_text_console_writer                                       |
// | Purpose   : Accepts a stream of character/control bytes and turns them    |
// |             into writes on a character map and a colour map for an 80x30  |
// |             text display, tracking the cursor. Form feed (and the         |
// |             power-up sequence) blanks all 2400 cells one per cycle.       |
// | Params    : CLEAR_CHAR    - character written into blanked cells          |
// |             DEFAULT_COLOR - colour written into blanked cells             |
// | Ports     : clk_25m in  pixel clock, rising edge                          |
// |             rst     in  synchronous active-high reset                     |
// |             bus     slave modport of vga_text_console_writer_if           |
// | Config    : VGA_CONSOLE_LINE_CLEAR_EN - when defined, every row advance   |
// |             also blanks the 80 cells of the new row (CLR_LINE state).     |
// | Revision  : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module vga_text_console_writer
  import vga_text_console_pkg::*;
#(
  parameter logic [7:0] CLEAR_CHAR    = 8'h20,
  parameter logic [7:0] DEFAULT_COLOR = 8'h0F
) (
  input  wire logic                 clk_25m,
  input  wire logic                 rst,
  vga_text_console_writer_if.slave  bus
);

  // Registered state and outputs
  state_t             r_state;
  logic               r_ready;
  logic               r_busy;
  logic               r_wen;
  logic [CELL_AW-1:0] r_addr;
  logic [7:0]         r_ch;
  logic [7:0]         r_col;
  logic [COL_W-1:0]   r_x;
  logic [ROW_W-1:0]   r_y;
  logic [CELL_AW-1:0] r_cnt;   // blanking position (cell or column)

  // Combinational helpers
  logic [COL_W-1:0]   w_addr_x;
  logic [CELL_AW-1:0] w_cell_addr;
  logic [COL_W-1:0]   w_next_x;
  logic [ROW_W-1:0]   w_next_y;
  logic               w_adv;
  logic               w_is_print;
  logic [7:0]         w_tab;
  logic               w_accept;

  assign w_accept = r_ready && bus.char_valid_i;

  // During a line clear the column comes from the blanking counter; the
  // cursor already sits at column 0 of the row being cleared.
`ifdef VGA_CONSOLE_LINE_CLEAR_EN
  assign w_addr_x = (r_state == CLR_LINE) ? r_cnt[COL_W-1:0] : r_x;
`else
  assign w_addr_x = r_x;
`endif

  vga_text_cell_addr u_cell_addr (
    .y    (r_y),
    .x    (w_addr_x),
    .addr (w_cell_addr)
  );

  // Next tab stop: (x/8 + 1) * 8, at most 80 for x in 72..79
  assign w_tab = {1'b0, r_x[6:3] + 4'd1, 3'b000};

  // Cursor movement for the byte on the bus
  always_comb begin
    w_next_x   = r_x;
    w_adv      = 1'b0;
    w_is_print = 1'b0;
    case (bus.char_data_i)
      C_CR: begin
        w_next_x = '0;
      end
      C_LF: begin
        w_next_x = '0;
        w_adv    = 1'b1;
      end
      C_BS: begin
        if (r_x != '0) begin
          w_next_x = r_x - 7'd1;
        end
      end
      C_HT: begin
        if (w_tab > 8'(COLS - 1)) begin
          w_next_x = '0;
          w_adv    = 1'b1;
        end else begin
          w_next_x = w_tab[COL_W-1:0];
        end
      end
      C_FF: begin
        w_next_x = r_x;
      end
      default: begin
        w_is_print = 1'b1;
        if (r_x == 7'(COLS - 1)) begin
          w_next_x = '0;
          w_adv    = 1'b1;
        end else begin
          w_next_x = r_x + 7'd1;
        end
      end
    endcase

    if (w_adv) begin
      w_next_y = (r_y == 5'(ROWS - 1)) ? '0 : r_y + 5'd1;
    end else begin
      w_next_y = r_y;
    end
  end

  // Control FSM with all outputs registered
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      r_state <= RST_HOLD;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_ch    <= '0;
      r_col   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
    end else begin
      r_wen <= 1'b0;
      case (r_state)
        RST_HOLD: begin
          r_state <= CLR_SCREEN;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_ready <= 1'b0;
        end

        IDLE: begin
          if (w_accept) begin
            if (w_is_print) begin
              r_wen  <= 1'b1;
              r_addr <= w_cell_addr;
              r_ch   <= bus.char_data_i;
              r_col  <= bus.color_i;
            end
            if (bus.char_data_i == C_FF) begin
              r_state <= CLR_SCREEN;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_ready <= 1'b0;
            end else begin
              r_x <= w_next_x;
              r_y <= w_next_y;
`ifdef VGA_CONSOLE_LINE_CLEAR_EN
              if (w_adv) begin
                r_state <= CLR_LINE;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
                r_ready <= 1'b0;
              end
`endif
            end
          end
        end

        CLR_SCREEN: begin
          r_wen  <= 1'b1;
          r_addr <= r_cnt;
          r_ch   <= CLEAR_CHAR;
          r_col  <= DEFAULT_COLOR;
          // Counter holds at the terminal cell instead of wrapping
          if (r_cnt == 12'(CELLS - 1)) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 12'd1;
          end
        end

`ifdef VGA_CONSOLE_LINE_CLEAR_EN
        CLR_LINE: begin
          r_wen  <= 1'b1;
          r_addr <= w_cell_addr;
          r_ch   <= CLEAR_CHAR;
          r_col  <= DEFAULT_COLOR;
          if (r_cnt == 12'(COLS - 1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 12'd1;
          end
        end
`endif

        default: begin
          r_state <= RST_HOLD;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Both map ports always share address and enable
  assign bus.char_ready_o   = r_ready;
  assign bus.busy_o         = r_busy;
  assign bus.ch_map_wen_o   = r_wen;
  assign bus.ch_map_addr_o  = r_addr;
  assign bus.ch_map_data_o  = r_ch;
  assign bus.col_map_wen_o  = r_wen;
  assign bus.col_map_addr_o = r_addr;
  assign bus.col_map_data_o = r_col;
  assign bus.cursor_x_o     = r_x;
  assign bus.cursor_y_o     = r_y;

endmodule

`default_nettype wire

// File: tb/tb_vga_text_console_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_vga_text_console_writer                                    |
// | Purpose   : Self-checking bench for vga_text_console_writer. A cursor     |
// |             model pushes expected map writes into a queue as bytes are    |
// |             sent; every DUT write is popped and compared in order.        |
// | Config    : honours VGA_CONSOLE_LINE_CLEAR_EN in its model.               |
// | Revision  : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_vga_text_console_writer;

  logic clk_25m = 1'b0;
  logic rst     = 1'b1;

  always #20 clk_25m = ~clk_25m;

  vga_text_console_writer_if bus ();

  vga_text_console_writer #(
    .CLEAR_CHAR    (8'h20),
    .DEFAULT_COLOR (8'h0F)
  ) dut (
    .clk_25m (clk_25m),
    .rst     (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [11:0] a;
    logic [7:0]  c;
    logic [7:0]  k;
  } wr_t;

  typedef struct {
    logic [7:0] ch;
    logic [7:0] col;
    int         ex;
    int         ey;
  } vec_t;

  wr_t  exp_q[$];
  vec_t tbl[10];
  int   checks  = 0;
  int   errors  = 0;
  int   wr_seen = 0;
  int   mx      = 0;
  int   my      = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic push_wr(input int a, input logic [7:0] c, input logic [7:0] k);
    wr_t e;
    e.a = 12'(a);
    e.c = c;
    e.k = k;
    exp_q.push_back(e);
  endtask

  task automatic push_screen_blank();
    for (int i = 0; i < 2400; i++) push_wr(i, 8'h20, 8'h0F);
  endtask

  // Reference cursor model
  task automatic model_step(input logic [7:0] c, input logic [7:0] k);
    bit adv;
    int t;
    adv = 1'b0;
    case (c)
      8'h0D: mx = 0;
      8'h0A: begin mx = 0; adv = 1'b1; end
      8'h08: if (mx > 0) mx = mx - 1;
      8'h09: begin
        t = (mx / 8 + 1) * 8;
        if (t > 79) begin mx = 0; adv = 1'b1; end
        else mx = t;
      end
      8'h0C: begin
        push_screen_blank();
        mx = 0;
        my = 0;
      end
      default: begin
        push_wr(my * 80 + mx, c, k);
        if (mx == 79) begin mx = 0; adv = 1'b1; end
        else mx = mx + 1;
      end
    endcase
    if (adv) begin
      my = (my == 29) ? 0 : my + 1;
`ifdef VGA_CONSOLE_LINE_CLEAR_EN
      for (int i = 0; i < 80; i++) push_wr(my * 80 + i, 8'h20, 8'h0F);
`endif
    end
  endtask

  // Scoreboard: called on every falling edge
  task automatic sb_check();
    wr_t e;
    if (rst) return;
    checks++;
    if (bus.col_map_wen_o !== bus.ch_map_wen_o) begin
      errors++;
      $display("FAIL wen_pair actual ch_wen=%b col_wen=%b required equal",
               bus.ch_map_wen_o, bus.col_map_wen_o);
    end
    if (bus.ch_map_wen_o !== 1'b1) return;
    wr_seen++;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL write_unexpected actual addr=%0d ch=%h required no write",
               bus.ch_map_addr_o, bus.ch_map_data_o);
      return;
    end
    e = exp_q.pop_front();
    if (bus.ch_map_addr_o !== e.a || bus.ch_map_data_o !== e.c ||
        bus.col_map_data_o !== e.k || bus.col_map_addr_o !== e.a) begin
      errors++;
      $display("FAIL write_cell actual addr=%0d/%0d ch=%h col=%h required addr=%0d ch=%h col=%h",
               bus.ch_map_addr_o, bus.col_map_addr_o, bus.ch_map_data_o,
               bus.col_map_data_o, e.a, e.c, e.k);
    end
  endtask

  task automatic tick();
    @(negedge clk_25m);
    sb_check();
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus.char_ready_o !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, 32'(bus.char_ready_o), 32'd1);
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] k);
    bit is_pr;
    wait_ready("pre_send");
    is_pr = !(c inside {8'h08, 8'h09, 8'h0A, 8'h0C, 8'h0D});
    model_step(c, k);
    bus.char_valid_i = 1'b1;
    bus.char_data_i  = c;
    bus.color_i      = k;
    tick();
    bus.char_valid_i = 1'b0;
    // Registered write appears right after the accepting edge
    chk("write_latency", 32'(bus.ch_map_wen_o), 32'(is_pr));
    wait_ready("post_send");
  endtask

  task automatic send_n(input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) send(c, 8'h1E);
  endtask

  task automatic chk_cursor(input string nm, input int x, input int y);
    chk({nm, "_x"}, 32'(bus.cursor_x_o), 32'(x));
    chk({nm, "_y"}, 32'(bus.cursor_y_o), 32'(y));
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_wen"},   32'(bus.ch_map_wen_o | bus.col_map_wen_o), 32'd0);
    chk({nm, "_addr"},  32'(bus.ch_map_addr_o | bus.col_map_addr_o), 32'd0);
    chk({nm, "_data"},  32'(bus.ch_map_data_o | bus.col_map_data_o), 32'd0);
    chk({nm, "_ready"}, 32'(bus.char_ready_o), 32'd0);
    chk({nm, "_busy"},  32'(bus.busy_o), 32'd0);
    chk_cursor(nm, 0, 0);
  endtask

  initial begin
    int target;
    int n;

    tbl[0] = '{8'h41, 8'h2A, 1,  0};   // 'A' at origin
    tbl[1] = '{8'h42, 8'h13, 2,  0};
    tbl[2] = '{8'h08, 8'h00, 1,  0};   // backspace
    tbl[3] = '{8'h09, 8'h00, 8,  0};   // tab
    tbl[4] = '{8'h0D, 8'h00, 0,  0};   // carriage return
    tbl[5] = '{8'h08, 8'h00, 0,  0};   // backspace at column 0
    tbl[6] = '{8'h0A, 8'h00, 0,  1};   // line feed
    tbl[7] = '{8'h43, 8'h5C, 1,  1};
    tbl[8] = '{8'h09, 8'h00, 8,  1};
    tbl[9] = '{8'h09, 8'h00, 16, 1};

    bus.char_valid_i = 1'b0;
    bus.char_data_i  = 8'h00;
    bus.color_i      = 8'h00;

    // Reset state
    rst = 1'b1;
    tick(); tick(); tick();
    chk_reset_outputs("reset");

    // Power-up blank
    rst = 1'b0;
    push_screen_blank();
    wait_ready("powerup");
    chk_cursor("powerup", 0, 0);
    chk("powerup_busy", 32'(bus.busy_o), 32'd0);

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].ch, tbl[i].col);
      chk_cursor($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey);
    end

    // Tab from (5,3) lands on 8
    send(8'h0D, 8'h00);
    send_n(8'h0A, 2);
    send_n(8'h61, 5);
    chk_cursor("at_5_3", 5, 3);
    send(8'h09, 8'h00);
    chk_cursor("tab_5_3", 8, 3);

    // Tab from (75,3) wraps to next row
    send(8'h0D, 8'h00);
    send_n(8'h09, 9);
    send_n(8'h62, 3);
    chk_cursor("at_75_3", 75, 3);
    send(8'h09, 8'h00);
    chk_cursor("tab_wrap", 0, 4);

    // Backspace at column 0 holds
    send_n(8'h0A, 3);
    chk_cursor("at_0_7", 0, 7);
    send(8'h08, 8'h00);
    chk_cursor("bs_col0", 0, 7);

    // Last cell then wrap to origin
    send_n(8'h0A, 22);
    send_n(8'h09, 9);
    send_n(8'h63, 7);
    chk_cursor("at_79_29", 79, 29);
    chk("model_at_last", 32'(my * 80 + mx), 32'd2399);
    send(8'h42, 8'h71);
    chk_cursor("wrap_origin", 0, 0);

    // Form feed, then reset part way through the blank
    wait_ready("pre_ff");
    model_step(8'h0C, 8'h00);
    bus.char_valid_i = 1'b1;
    bus.char_data_i  = 8'h0C;
    tick();
    bus.char_valid_i = 1'b0;
    chk("ff_busy", 32'(bus.busy_o), 32'd1);
    chk("ff_ready", 32'(bus.char_ready_o), 32'd0);
    target = wr_seen + 100;
    n = 0;
    while (wr_seen < target && n < 500) begin
      tick();
      n++;
    end
    chk("ff_progress", 32'(wr_seen >= target), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    tick();
    chk_reset_outputs("midreset");
    rst = 1'b0;
    push_screen_blank();
    mx = 0;
    my = 0;
    wait_ready("restart");
    chk_cursor("restart", 0, 0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
